// File: rtl/axi_address_remapper_pkg.sv
// Shared constants for the AXI address remapper: register map, INFO magic,
// response codes and FSM state encodings.
package axi_address_remapper_pkg;

  localparam int unsigned CTRL_OFS       = 32'h00;
  localparam int unsigned DEF_OFS        = 32'h04;
  localparam int unsigned INFO_OFS       = 32'h08;
  localparam int unsigned WIN_OFS        = 32'h10;
  localparam int unsigned WIN_STRIDE     = 16;
  localparam int unsigned WIN_BASE_OFS   = 0;
  localparam int unsigned WIN_LIMIT_OFS  = 4;
  localparam int unsigned WIN_OFFSET_OFS = 8;
  localparam int unsigned WIN_RSVD_OFS   = 12;

  localparam logic [15:0] INFO_MAGIC = 16'h52E2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [2:0] w_state_t;
  localparam w_state_t W_IDLE    = 3'd0;
  localparam w_state_t W_WAIT_W  = 3'd1;
  localparam w_state_t W_WAIT_AW = 3'd2;
  localparam w_state_t W_COMMIT  = 3'd3;
  localparam w_state_t W_RESP    = 3'd4;

  typedef logic [0:0] r_state_t;
  localparam r_state_t R_IDLE = 1'b0;
  localparam r_state_t R_DATA = 1'b1;

  function automatic logic [31:0] win_reg_ofs(input int unsigned idx, input int unsigned sub);
    return WIN_OFS + WIN_STRIDE * idx + sub;
  endfunction

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++)
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    return res;
  endfunction

endpackage

// File: rtl/axi_address_remapper_if.sv
// AXI-Lite configuration bus of the address remapper.
interface axi_address_remapper_if #(
  parameter int AXI_ADDR_WIDTH_SLAVE = 8,
  parameter int AXI_DATA_WIDTH       = 32
);
  logic [AXI_ADDR_WIDTH_SLAVE-1:0] s00_axi_awaddr;
  logic                            s00_axi_awvalid;
  logic                            s00_axi_awready;
  logic [AXI_DATA_WIDTH-1:0]       s00_axi_wdata;
  logic [3:0]                      s00_axi_wstrb;
  logic                            s00_axi_wvalid;
  logic                            s00_axi_wready;
  logic [1:0]                      s00_axi_bresp;
  logic                            s00_axi_bvalid;
  logic                            s00_axi_bready;
  logic [AXI_ADDR_WIDTH_SLAVE-1:0] s00_axi_araddr;
  logic                            s00_axi_arvalid;
  logic                            s00_axi_arready;
  logic [AXI_DATA_WIDTH-1:0]       s00_axi_rdata;
  logic [1:0]                      s00_axi_rresp;
  logic                            s00_axi_rvalid;
  logic                            s00_axi_rready;

  modport slave (
    input  s00_axi_awaddr, s00_axi_awvalid, output s00_axi_awready,
    input  s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid, output s00_axi_wready,
    output s00_axi_bresp, s00_axi_bvalid, input s00_axi_bready,
    input  s00_axi_araddr, s00_axi_arvalid, output s00_axi_arready,
    output s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid, input s00_axi_rready
  );

  modport master (
    output s00_axi_awaddr, s00_axi_awvalid, input s00_axi_awready,
    output s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid, input s00_axi_wready,
    input  s00_axi_bresp, s00_axi_bvalid, output s00_axi_bready,
    output s00_axi_araddr, s00_axi_arvalid, input s00_axi_arready,
    input  s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid, output s00_axi_rready
  );
endinterface

// File: rtl/axi_address_remapper_window_match.sv
// Combinational window lookup for one address channel: lowest matching
// window wins, otherwise the optional default offset applies.
module addr_window_match #(
  parameter int AW = 32,
  parameter int NW = 4
) (
  input  logic [AW-1:0]         addr,
  input  logic                  en,
  input  logic                  def_en,
  input  logic [AW-1:0]         def_offset,
  input  logic [NW-1:0][AW-1:0] base,
  input  logic [NW-1:0][AW-1:0] limit,
  input  logic [NW-1:0][AW-1:0] offset,
  output logic [AW-1:0]         addr_out,
  output logic                  hit
);
  logic found;

  always_comb begin
    addr_out = addr;
    hit      = 1'b0;
    found    = 1'b0;
    if (en) begin
      // An inverted window (limit < base) can never satisfy both compares.
      for (int i = 0; i < NW; i++) begin
        if (!found && (base[i] <= addr) && (addr <= limit[i])) begin
          found    = 1'b1;
          addr_out = addr + offset[i];
        end
      end
      hit = found;
      if (!found && def_en) addr_out = addr + def_offset;
    end
  end
endmodule

// File: rtl/axi_address_remapper.sv
// AXI address remapper: AXI-Lite register file plus per-channel translation.
// state     | meaning
// W_IDLE    | waiting for AW and/or W
// W_WAIT_W  | AW captured, waiting for W
// W_WAIT_AW | W captured, waiting for AW
// W_COMMIT  | decode and update registers
// W_RESP    | bvalid high until bready
// R_IDLE    | waiting for AR
// R_DATA    | rvalid high until rready
module axi_address_remapper
  import axi_address_remapper_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH       = 32,
  parameter int AXI_DATA_WIDTH       = 32,
  parameter int NUM_WINDOWS          = 4,
  parameter int AXI_ADDR_WIDTH_SLAVE = 8
) (
  input  logic                      s00_axi_aclk,
  input  logic                      s00_axi_areset,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_master_awaddr_in,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_master_araddr_in,
  output logic [AXI_ADDR_WIDTH-1:0] axi_master_awaddr_out,
  output logic [AXI_ADDR_WIDTH-1:0] axi_master_araddr_out,
  output logic                      axi_master_aw_hit,
  output logic                      axi_master_ar_hit,
  axi_address_remapper_if.slave     s00_axi
);
  localparam int DW = AXI_DATA_WIDTH;

  logic [1:0]    ctrl_q;
  logic [DW-1:0] def_offset_q;
  logic [DW-1:0] base_q   [NUM_WINDOWS];
  logic [DW-1:0] limit_q  [NUM_WINDOWS];
  logic [DW-1:0] offset_q [NUM_WINDOWS];

  w_state_t                        w_state;
  r_state_t                        r_state;
  logic [AXI_ADDR_WIDTH_SLAVE-1:0] aw_addr_q;
  logic [DW-1:0]                   w_data_q;
  logic [3:0]                      w_strb_q;
  logic [1:0]                      bresp_q;
  logic [DW-1:0]                   rdata_q;
  logic [1:0]                      rresp_q;

  logic [31:0]            wr_ofs, rd_ofs;
  logic                   wr_ok, wr_ctrl, wr_def;
  logic [NUM_WINDOWS-1:0] wr_base, wr_limit, wr_off;
  logic [DW-1:0]          wr_old, wr_merged;
  logic [DW-1:0]          rd_data;
  logic [1:0]             rd_resp;

  assign wr_ofs = 32'({aw_addr_q[AXI_ADDR_WIDTH_SLAVE-1:2], 2'b00});
  assign rd_ofs = 32'({s00_axi.s00_axi_araddr[AXI_ADDR_WIDTH_SLAVE-1:2], 2'b00});

  always_comb begin
    wr_ok    = 1'b0;
    wr_ctrl  = 1'b0;
    wr_def   = 1'b0;
    wr_base  = '0;
    wr_limit = '0;
    wr_off   = '0;
    wr_old   = '0;
    if (wr_ofs == CTRL_OFS) begin
      wr_ok = 1'b1; wr_ctrl = 1'b1; wr_old = DW'(ctrl_q);
    end else if (wr_ofs == DEF_OFS) begin
      wr_ok = 1'b1; wr_def = 1'b1; wr_old = def_offset_q;
    end
    for (int i = 0; i < NUM_WINDOWS; i++) begin
      if (wr_ofs == win_reg_ofs(i, WIN_BASE_OFS)) begin
        wr_ok = 1'b1; wr_base[i] = 1'b1; wr_old = base_q[i];
      end
      if (wr_ofs == win_reg_ofs(i, WIN_LIMIT_OFS)) begin
        wr_ok = 1'b1; wr_limit[i] = 1'b1; wr_old = limit_q[i];
      end
      if (wr_ofs == win_reg_ofs(i, WIN_OFFSET_OFS)) begin
        wr_ok = 1'b1; wr_off[i] = 1'b1; wr_old = offset_q[i];
      end
    end
  end

  assign wr_merged = apply_strb(wr_old, w_data_q, w_strb_q);

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_SLVERR;
    if (rd_ofs == CTRL_OFS) begin
      rd_data = DW'(ctrl_q); rd_resp = RESP_OKAY;
    end else if (rd_ofs == DEF_OFS) begin
      rd_data = def_offset_q; rd_resp = RESP_OKAY;
    end else if (rd_ofs == INFO_OFS) begin
      rd_data = {INFO_MAGIC, 8'd0, 8'(NUM_WINDOWS)}; rd_resp = RESP_OKAY;
    end
    for (int i = 0; i < NUM_WINDOWS; i++) begin
      if (rd_ofs == win_reg_ofs(i, WIN_BASE_OFS)) begin
        rd_data = base_q[i]; rd_resp = RESP_OKAY;
      end
      if (rd_ofs == win_reg_ofs(i, WIN_LIMIT_OFS)) begin
        rd_data = limit_q[i]; rd_resp = RESP_OKAY;
      end
      if (rd_ofs == win_reg_ofs(i, WIN_OFFSET_OFS)) begin
        rd_data = offset_q[i]; rd_resp = RESP_OKAY;
      end
      if (rd_ofs == win_reg_ofs(i, WIN_RSVD_OFS)) begin
        rd_data = '0; rd_resp = RESP_OKAY;
      end
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      w_state   <= W_IDLE;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (s00_axi.s00_axi_awvalid) aw_addr_q <= s00_axi.s00_axi_awaddr;
          if (s00_axi.s00_axi_wvalid) begin
            w_data_q <= s00_axi.s00_axi_wdata;
            w_strb_q <= s00_axi.s00_axi_wstrb;
          end
          if (s00_axi.s00_axi_awvalid && s00_axi.s00_axi_wvalid) w_state <= W_COMMIT;
          else if (s00_axi.s00_axi_awvalid)                      w_state <= W_WAIT_W;
          else if (s00_axi.s00_axi_wvalid)                       w_state <= W_WAIT_AW;
        end
        W_WAIT_W: begin
          if (s00_axi.s00_axi_wvalid) begin
            w_data_q <= s00_axi.s00_axi_wdata;
            w_strb_q <= s00_axi.s00_axi_wstrb;
            w_state  <= W_COMMIT;
          end
        end
        W_WAIT_AW: begin
          if (s00_axi.s00_axi_awvalid) begin
            aw_addr_q <= s00_axi.s00_axi_awaddr;
            w_state   <= W_COMMIT;
          end
        end
        W_COMMIT: begin
          bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
          w_state <= W_RESP;
        end
        W_RESP:  if (s00_axi.s00_axi_bready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      ctrl_q       <= '0;
      def_offset_q <= '0;
      for (int i = 0; i < NUM_WINDOWS; i++) begin
        base_q[i]   <= '0;
        limit_q[i]  <= '0;
        offset_q[i] <= '0;
      end
    end else if (w_state == W_COMMIT) begin
      if (wr_ctrl) ctrl_q       <= wr_merged[1:0];
      if (wr_def)  def_offset_q <= wr_merged;
      for (int i = 0; i < NUM_WINDOWS; i++) begin
        if (wr_base[i])  base_q[i]   <= wr_merged;
        if (wr_limit[i]) limit_q[i]  <= wr_merged;
        if (wr_off[i])   offset_q[i] <= wr_merged;
      end
    end
  end

  // Read path samples the registers as they stand, so it sees pre-commit values.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      r_state <= R_IDLE;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s00_axi.s00_axi_arvalid) begin
            rdata_q <= rd_data;
            rresp_q <= rd_resp;
            r_state <= R_DATA;
          end
        end
        R_DATA:  if (s00_axi.s00_axi_rready) r_state <= R_IDLE;
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign s00_axi.s00_axi_awready = !s00_axi_areset && (w_state == W_IDLE || w_state == W_WAIT_AW);
  assign s00_axi.s00_axi_wready  = !s00_axi_areset && (w_state == W_IDLE || w_state == W_WAIT_W);
  assign s00_axi.s00_axi_bvalid  = !s00_axi_areset && (w_state == W_RESP);
  assign s00_axi.s00_axi_bresp   = s00_axi_areset ? RESP_OKAY : bresp_q;
  assign s00_axi.s00_axi_arready = !s00_axi_areset && (r_state == R_IDLE);
  assign s00_axi.s00_axi_rvalid  = !s00_axi_areset && (r_state == R_DATA);
  assign s00_axi.s00_axi_rdata   = s00_axi_areset ? '0 : rdata_q;
  assign s00_axi.s00_axi_rresp   = s00_axi_areset ? RESP_OKAY : rresp_q;

  logic [NUM_WINDOWS-1:0][AXI_ADDR_WIDTH-1:0] base_p, limit_p, offset_p;

  for (genvar g = 0; g < NUM_WINDOWS; g++) begin : g_flat
    assign base_p[g]   = AXI_ADDR_WIDTH'(base_q[g]);
    assign limit_p[g]  = AXI_ADDR_WIDTH'(limit_q[g]);
    assign offset_p[g] = AXI_ADDR_WIDTH'(offset_q[g]);
  end

  addr_window_match #(.AW(AXI_ADDR_WIDTH), .NW(NUM_WINDOWS)) u_aw_match (
    .addr       (axi_master_awaddr_in),
    .en         (ctrl_q[0]),
    .def_en     (ctrl_q[1]),
    .def_offset (AXI_ADDR_WIDTH'(def_offset_q)),
    .base       (base_p),
    .limit      (limit_p),
    .offset     (offset_p),
    .addr_out   (axi_master_awaddr_out),
    .hit        (axi_master_aw_hit)
  );

  addr_window_match #(.AW(AXI_ADDR_WIDTH), .NW(NUM_WINDOWS)) u_ar_match (
    .addr       (axi_master_araddr_in),
    .en         (ctrl_q[0]),
    .def_en     (ctrl_q[1]),
    .def_offset (AXI_ADDR_WIDTH'(def_offset_q)),
    .base       (base_p),
    .limit      (limit_p),
    .offset     (offset_p),
    .addr_out   (axi_master_araddr_out),
    .hit        (axi_master_ar_hit)
  );
endmodule

// File: tb/tb_axi_address_remapper.sv
// Self-checking bench for axi_address_remapper: bus responses go through
// expected-value queues, translation results are checked against tables.
module tb_axi_address_remapper;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr_in = '0, araddr_in = '0;
  logic [31:0] awaddr_out, araddr_out;
  logic        aw_hit, ar_hit;

  int vectors = 0;
  int miscompares = 0;

  logic [1:0]  wr_exp_q [$];
  logic [33:0] rd_exp_q [$];

  axi_address_remapper_if #(.AXI_ADDR_WIDTH_SLAVE(8), .AXI_DATA_WIDTH(32)) bus ();

  axi_address_remapper #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .NUM_WINDOWS(4), .AXI_ADDR_WIDTH_SLAVE(8)
  ) dut (
    .s00_axi_aclk          (clk),
    .s00_axi_areset        (rst),
    .axi_master_awaddr_in  (awaddr_in),
    .axi_master_araddr_in  (araddr_in),
    .axi_master_awaddr_out (awaddr_out),
    .axi_master_araddr_out (araddr_out),
    .axi_master_aw_hit     (aw_hit),
    .axi_master_ar_hit     (ar_hit),
    .s00_axi               (bus)
  );

  always #5 clk = ~clk;

  // mode 0: AW and W together, 1: AW first, 2: W first
  task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int mode, input logic [1:0] exp_resp, input int stall);
    int cyc; logic aw_hs, w_hs, aw_done, w_done; logic [1:0] e;
    wr_exp_q.push_back(exp_resp);
    @(negedge clk);
    bus.s00_axi_awaddr  = a;
    bus.s00_axi_wdata   = d;
    bus.s00_axi_wstrb   = s;
    bus.s00_axi_awvalid = (mode != 2);
    bus.s00_axi_wvalid  = (mode != 1);
    cyc = 0; aw_done = 1'b0; w_done = 1'b0;
    while (!(aw_done && w_done) && cyc < 50) begin
      aw_hs = bus.s00_axi_awvalid && bus.s00_axi_awready;
      w_hs  = bus.s00_axi_wvalid && bus.s00_axi_wready;
      @(negedge clk); cyc++;
      if (aw_hs) begin bus.s00_axi_awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin bus.s00_axi_wvalid  = 1'b0; w_done  = 1'b1; end
      if (mode == 1 && aw_done && !w_done && !bus.s00_axi_wvalid) bus.s00_axi_wvalid = 1'b1;
      if (mode == 2 && w_done && !aw_done && !bus.s00_axi_awvalid) bus.s00_axi_awvalid = 1'b1;
    end
    bus.s00_axi_awvalid = 1'b0;
    bus.s00_axi_wvalid  = 1'b0;
    bus.s00_axi_bready  = (stall == 0);
    cyc = 0;
    while (!bus.s00_axi_bvalid && cyc < 50) begin @(negedge clk); cyc++; end
    e = wr_exp_q.pop_front();
    vectors++;
    if (bus.s00_axi_bvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_timeout addr=%h: bvalid=%b want 1", a, bus.s00_axi_bvalid);
    end else if (bus.s00_axi_bresp !== e) begin
      miscompares++;
      $display("FAIL bresp addr=%h: got %b want %b", a, bus.s00_axi_bresp, e);
    end
    for (int k = 0; k < stall; k++) begin
      bus.s00_axi_awaddr  = 8'h00;
      bus.s00_axi_awvalid = 1'b1;
      @(negedge clk);
      vectors++;
      if (bus.s00_axi_bvalid !== 1'b1 || bus.s00_axi_awready !== 1'b0) begin
        miscompares++;
        $display("FAIL b_stall cycle %0d: bvalid=%b awready=%b want 1 0", k,
                 bus.s00_axi_bvalid, bus.s00_axi_awready);
      end
    end
    bus.s00_axi_awvalid = 1'b0;
    bus.s00_axi_bready  = 1'b1;
    @(negedge clk);
    bus.s00_axi_bready  = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r);
    int cyc; logic [33:0] e;
    rd_exp_q.push_back({exp_r, exp_d});
    @(negedge clk);
    bus.s00_axi_araddr  = a;
    bus.s00_axi_arvalid = 1'b1;
    cyc = 0;
    while (!bus.s00_axi_arready && cyc < 50) begin @(negedge clk); cyc++; end
    @(negedge clk);
    bus.s00_axi_arvalid = 1'b0;
    bus.s00_axi_rready  = 1'b1;
    cyc = 0;
    while (!bus.s00_axi_rvalid && cyc < 50) begin @(negedge clk); cyc++; end
    e = rd_exp_q.pop_front();
    vectors++;
    if (bus.s00_axi_rvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_timeout addr=%h: rvalid=%b want 1", a, bus.s00_axi_rvalid);
    end else if ({bus.s00_axi_rresp, bus.s00_axi_rdata} !== e) begin
      miscompares++;
      $display("FAIL rdata addr=%h: got resp=%b data=%h want resp=%b data=%h", a,
               bus.s00_axi_rresp, bus.s00_axi_rdata, e[33:32], e[31:0]);
    end
    @(negedge clk);
    bus.s00_axi_rready = 1'b0;
  endtask

  task automatic check_xlate(input string name, input logic [31:0] ins [],
                             input logic [31:0] outs [], input logic hits []);
    for (int i = 0; i < ins.size(); i++) begin
      awaddr_in = ins[i];
      araddr_in = ins[i];
      #1;
      vectors++;
      if (awaddr_out !== outs[i] || aw_hit !== hits[i]) begin
        miscompares++;
        $display("FAIL %s aw in=%h: got %h hit=%b want %h hit=%b", name, ins[i],
                 awaddr_out, aw_hit, outs[i], hits[i]);
      end
      vectors++;
      if (araddr_out !== outs[i] || ar_hit !== hits[i]) begin
        miscompares++;
        $display("FAIL %s ar in=%h: got %h hit=%b want %h hit=%b", name, ins[i],
                 araddr_out, ar_hit, outs[i], hits[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.s00_axi_awready, bus.s00_axi_wready, bus.s00_axi_arready,
         bus.s00_axi_bvalid, bus.s00_axi_rvalid} !== 5'b0 || bus.s00_axi_rdata !== 32'h0 ||
        bus.s00_axi_bresp !== 2'b00 || bus.s00_axi_rresp !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_outputs: rdy=%b%b%b bv=%b rv=%b rdata=%h want all 0",
               bus.s00_axi_awready, bus.s00_axi_wready, bus.s00_axi_arready,
               bus.s00_axi_bvalid, bus.s00_axi_rvalid, bus.s00_axi_rdata);
    end
    rst = 1'b0;
    check_xlate("reset_pass", '{32'h1234_5678}, '{32'h1234_5678}, '{1'b0});
    bus_read(8'h08, 32'h52E2_0004, 2'b00);
  endtask

  task automatic test_write_modes();
    bus_write(8'h10, 32'h0000_1000, 4'hF, 0, 2'b00, 0);
    bus_write(8'h14, 32'h0000_1FFF, 4'hF, 1, 2'b00, 0);
    bus_write(8'h18, 32'h8000_0000, 4'hF, 2, 2'b00, 0);
    bus_read(8'h10, 32'h0000_1000, 2'b00);
    bus_read(8'h14, 32'h0000_1FFF, 2'b00);
    bus_read(8'h18, 32'h8000_0000, 2'b00);
    check_xlate("disabled", '{32'h1FFC}, '{32'h1FFC}, '{1'b0});
    bus_write(8'h00, 32'h0000_0001, 4'hF, 0, 2'b00, 0);
  endtask

  task automatic test_single_window();
    check_xlate("win0", '{32'h1FFC, 32'h2000, 32'h1000, 32'h0FFF},
                '{32'h8000_1FFC, 32'h2000, 32'h8000_1000, 32'h0FFF},
                '{1'b1, 1'b0, 1'b1, 1'b0});
  endtask

  task automatic test_priority_default();
    bus_write(8'h20, 32'h0000_0800, 4'hF, 0, 2'b00, 0);
    bus_write(8'h24, 32'h0000_17FF, 4'hF, 0, 2'b00, 0);
    bus_write(8'h28, 32'h4000_0000, 4'hF, 0, 2'b00, 0);
    bus_write(8'h04, 32'h0000_0010, 4'hF, 0, 2'b00, 0);
    check_xlate("no_default", '{32'h3000}, '{32'h3000}, '{1'b0});
    bus_write(8'h00, 32'h0000_0003, 4'hF, 0, 2'b00, 0);
    check_xlate("priority", '{32'h1000, 32'h0900, 32'h3000},
                '{32'h8000_1000, 32'h4000_0900, 32'h3010}, '{1'b1, 1'b1, 1'b0});
  endtask

  task automatic test_wrap_and_inverted();
    bus_write(8'h18, 32'hFFFF_F000, 4'hF, 0, 2'b00, 0);
    bus_write(8'h30, 32'h0000_5000, 4'hF, 0, 2'b00, 0);
    bus_write(8'h34, 32'h0000_4000, 4'hF, 0, 2'b00, 0);
    bus_write(8'h38, 32'h0000_0100, 4'hF, 0, 2'b00, 0);
    check_xlate("wrap_inv", '{32'h1800, 32'h4800, 32'h5000},
                '{32'h0000_0800, 32'h4810, 32'h5010}, '{1'b1, 1'b0, 1'b0});
  endtask

  task automatic test_strobes_and_errors();
    bus_write(8'h40, 32'hAABB_CCDD, 4'b0010, 0, 2'b00, 0);
    bus_read(8'h40, 32'h0000_CC00, 2'b00);
    bus_write(8'h08, 32'hFFFF_FFFF, 4'hF, 0, 2'b10, 0);
    bus_read(8'h08, 32'h52E2_0004, 2'b00);
    bus_write(8'h1C, 32'h1234_5678, 4'hF, 1, 2'b10, 0);
    bus_read(8'h1C, 32'h0, 2'b00);
    bus_write(8'h0C, 32'h1234_5678, 4'hF, 2, 2'b10, 0);
    bus_read(8'h0C, 32'h0, 2'b10);
    bus_read(8'h50, 32'h0, 2'b10);
    bus_read(8'h13, 32'h0000_1000, 2'b00);
    bus_read(8'h00, 32'h0000_0003, 2'b00);
  endtask

  task automatic test_back_to_back_stall();
    bus_write(8'h04, 32'h0000_0020, 4'hF, 0, 2'b00, 5);
    bus_read(8'h04, 32'h0000_0020, 2'b00);
    check_xlate("new_default", '{32'h3000}, '{32'h3020}, '{1'b0});
  endtask

  task automatic test_reset_in_resp();
    int cyc;
    @(negedge clk);
    bus.s00_axi_awaddr = 8'h04; bus.s00_axi_wdata = 32'h77; bus.s00_axi_wstrb = 4'hF;
    bus.s00_axi_awvalid = 1'b1; bus.s00_axi_wvalid = 1'b1; bus.s00_axi_bready = 1'b0;
    @(negedge clk);
    bus.s00_axi_awvalid = 1'b0; bus.s00_axi_wvalid = 1'b0;
    cyc = 0;
    while (!bus.s00_axi_bvalid && cyc < 20) begin @(negedge clk); cyc++; end
    vectors++;
    if (bus.s00_axi_bvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL resp_before_reset: bvalid=%b want 1", bus.s00_axi_bvalid);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.s00_axi_bvalid !== 1'b0 || bus.s00_axi_awready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_resp: bvalid=%b awready=%b want 0 1",
               bus.s00_axi_bvalid, bus.s00_axi_awready);
    end
    check_xlate("post_reset", '{32'h1800, 32'h3000}, '{32'h1800, 32'h3000}, '{1'b0, 1'b0});
    bus_read(8'h10, 32'h0, 2'b00);
  endtask

  initial begin
    bus.s00_axi_awaddr = '0; bus.s00_axi_awvalid = 1'b0;
    bus.s00_axi_wdata  = '0; bus.s00_axi_wstrb   = '0; bus.s00_axi_wvalid = 1'b0;
    bus.s00_axi_bready = 1'b0;
    bus.s00_axi_araddr = '0; bus.s00_axi_arvalid = 1'b0; bus.s00_axi_rready = 1'b0;
    test_reset();
    test_write_modes();
    test_single_window();
    test_priority_default();
    test_wrap_and_inverted();
    test_strobes_and_errors();
    test_back_to_back_stall();
    test_reset_in_resp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
